// File: rtl/freq_pkt_pkg.sv
// Shared types, packet layout constants and sizing helpers for freq_meas_packetizer.
// FREQ_PKT_CHECKSUM_EN appends an XOR checksum byte to every packet.
package freq_pkt_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    localparam int SYNC_OFFSET      = 0;
    localparam int SEQ_OFFSET       = 1;
    localparam int TIME_HIGH_OFFSET = 2;

`ifdef FREQ_PKT_CHECKSUM_EN
    localparam bit CHECKSUM_EN = 1'b1;
`else
    localparam bit CHECKSUM_EN = 1'b0;
`endif

    function automatic int time_low_offset(input int meas_width);
        return TIME_HIGH_OFFSET + meas_width / 8;
    endfunction

    function automatic int period_offset(input int meas_width);
        return TIME_HIGH_OFFSET + 2 * (meas_width / 8);
    endfunction

    // Sync + seq + three words, plus one byte when the checksum is enabled.
    function automatic int pkt_bytes(input int meas_width, input bit checksum_en);
        return 2 + 3 * (meas_width / 8) + (checksum_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/freq_meas_packetizer_if.sv
// Measurement input and byte-stream output bundle of freq_meas_packetizer.
// slave is the packetizer side; master is the producer/sink side.
interface freq_meas_packetizer_if #(
    parameter int MEAS_WIDTH = 32
);
    logic                  meas_valid;
    logic [MEAS_WIDTH-1:0] time_high;
    logic [MEAS_WIDTH-1:0] time_low;
    logic [MEAS_WIDTH-1:0] period;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx_last;
    logic                  busy;
    logic [7:0]            drop_count;

    modport master (
        output meas_valid, time_high, time_low, period, tx_ready,
        input  tx_data, tx_valid, tx_last, busy, drop_count
    );

    modport slave (
        input  meas_valid, time_high, time_low, period, tx_ready,
        output tx_data, tx_valid, tx_last, busy, drop_count
    );
endinterface

// File: rtl/freq_pkt_byte_mux.sv
// Selects the packet byte at idx_i from the snapshot, MSB byte of each word first.
// FREQ_PKT_CHECKSUM_EN adds the XOR of bytes SEQ..last PERIOD byte at index N.
module freq_pkt_byte_mux
    import freq_pkt_pkg::*;
#(
    parameter int         MEAS_WIDTH = 32,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT,
    parameter int         IDX_W      = 4
) (
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [7:0]            seq_i,
    input  logic [MEAS_WIDTH-1:0] time_high_i,
    input  logic [MEAS_WIDTH-1:0] time_low_i,
    input  logic [MEAS_WIDTH-1:0] period_i,
    output logic [7:0]            byte_o
);
    localparam int WORD_BYTES = MEAS_WIDTH / 8;
    localparam int BASE_BYTES = pkt_bytes(MEAS_WIDTH, 1'b0);
    localparam int TL_OFFSET  = time_low_offset(MEAS_WIDTH);
    localparam int PER_OFFSET = period_offset(MEAS_WIDTH);

    logic [7:0] field_bytes [BASE_BYTES];

    assign field_bytes[SYNC_OFFSET] = SYNC_BYTE;
    assign field_bytes[SEQ_OFFSET]  = seq_i;

    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_word_bytes
        localparam int HI = MEAS_WIDTH - 1 - 8 * gi;
        assign field_bytes[TIME_HIGH_OFFSET + gi] = time_high_i[HI -: 8];
        assign field_bytes[TL_OFFSET + gi]        = time_low_i[HI -: 8];
        assign field_bytes[PER_OFFSET + gi]       = period_i[HI -: 8];
    end

`ifdef FREQ_PKT_CHECKSUM_EN
    logic [7:0] checksum;

    always_comb begin
        checksum = '0;
        for (int i = SEQ_OFFSET; i < BASE_BYTES; i++) begin
            checksum = checksum ^ field_bytes[i];
        end
    end
`endif

    always_comb begin
        byte_o = '0;
        for (int i = 0; i < BASE_BYTES; i++) begin
            if (idx_i == IDX_W'(i)) begin
                byte_o = field_bytes[i];
            end
        end
`ifdef FREQ_PKT_CHECKSUM_EN
        if (idx_i == IDX_W'(BASE_BYTES)) begin
            byte_o = checksum;
        end
`endif
    end
endmodule

// File: rtl/freq_meas_packetizer.sv
// Snapshots each measurement and streams it as a framed byte packet with sequence numbering
// and a saturating drop counter. FREQ_PKT_CHECKSUM_EN appends a trailing XOR checksum byte.
module freq_meas_packetizer
    import freq_pkt_pkg::*;
#(
    parameter int         MEAS_WIDTH = 32,    // multiple of 8, at least 8
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    freq_meas_packetizer_if.slave  bus
);
    localparam int                PKT_LEN  = pkt_bytes(MEAS_WIDTH, CHECKSUM_EN);
    localparam int                IDX_W    = $clog2(PKT_LEN);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PKT_LEN - 1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [7:0]            seq_q, seq_d;
    logic [7:0]            snap_seq_q, snap_seq_d;
    logic [7:0]            drop_q, drop_d;
    logic [MEAS_WIDTH-1:0] th_q, th_d;
    logic [MEAS_WIDTH-1:0] tl_q, tl_d;
    logic [MEAS_WIDTH-1:0] per_q, per_d;
    logic [7:0]            mux_byte;

    logic handshake, last_hs, capture, drop;

    assign handshake = (state_q == SEND) && bus.tx_ready;
    assign last_hs   = handshake && (idx_q == LAST_IDX);
    // A strobe on the final handshake starts the next packet instead of being dropped.
    assign capture   = bus.meas_valid && ((state_q == IDLE) || last_hs);
    assign drop      = bus.meas_valid && (state_q == SEND) && !last_hs;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        seq_d      = seq_q;
        snap_seq_d = snap_seq_q;
        drop_d     = drop_q;
        th_d       = th_q;
        tl_d       = tl_q;
        per_d      = per_q;
        if (capture) begin
            state_d    = SEND;
            idx_d      = '0;
            seq_d      = seq_q + 8'd1;
            snap_seq_d = seq_q;
            th_d       = bus.time_high;
            tl_d       = bus.time_low;
            per_d      = bus.period;
        end else if (last_hs) begin
            state_d = IDLE;
        end else if (handshake) begin
            idx_d = idx_q + IDX_W'(1);
        end
        if (drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            seq_q      <= '0;
            snap_seq_q <= '0;
            drop_q     <= '0;
            th_q       <= '0;
            tl_q       <= '0;
            per_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            seq_q      <= seq_d;
            snap_seq_q <= snap_seq_d;
            drop_q     <= drop_d;
            th_q       <= th_d;
            tl_q       <= tl_d;
            per_q      <= per_d;
        end
    end

    freq_pkt_byte_mux #(
        .MEAS_WIDTH (MEAS_WIDTH),
        .SYNC_BYTE  (SYNC_BYTE),
        .IDX_W      (IDX_W)
    ) u_byte_mux (
        .idx_i       (idx_q),
        .seq_i       (snap_seq_q),
        .time_high_i (th_q),
        .time_low_i  (tl_q),
        .period_i    (per_q),
        .byte_o      (mux_byte)
    );

    // Outputs derive only from registers, so they hold still while the sink stalls.
    assign bus.tx_valid   = (state_q == SEND);
    assign bus.busy       = (state_q == SEND);
    assign bus.tx_data    = (state_q == SEND) ? mux_byte : 8'h00;
    assign bus.tx_last    = (state_q == SEND) && (idx_q == LAST_IDX);
    assign bus.drop_count = drop_q;
endmodule
